// File: rtl/multicycle_sequencer.sv
// Main control FSM of the multi-cycle RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with both memories, selects the PC source and traps.
module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       op_class,
    input  logic [2:0]       branch,
    input  logic             zero,
    input  logic             less,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_we,
    output logic             pc_we,
    output logic             PCBsrc,
    output logic             PCAsrc,
    output logic [CNT_W-1:0] instret,
    output logic [1:0]       fault_code,
    output logic             halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] OP_ALU     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_STORE   = 3'd2;
    localparam logic [2:0] OP_BRANCH  = 3'd3;
    localparam logic [2:0] OP_JAL     = 3'd4;
    localparam logic [2:0] OP_JALR    = 3'd5;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam logic [2:0] BR_ILLEGAL = 3'b011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_IMEM    = 2'b01;
    localparam logic [1:0] FAULT_DMEM    = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [2:0]       state, state_nxt;
    logic [2:0]       op_q, br_q;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] instret_q;
    logic [1:0]       fault_q, fault_nxt;
    logic             retire;
    logic             req_stall;

    logic imem_req_r, ir_we_r, dmem_req_r, dmem_we_r, reg_we_r, pc_we_r, halted_r;
    logic [1:0] pc_sel_r;

    // {PCBsrc,PCAsrc}: 00 = pc+4, 01 = pc+imm, 11 = rs1+imm.
    function automatic logic [1:0] branch_sel(input logic [2:0] br, input logic z, input logic l);
        logic [1:0] sel;
        sel = 2'b00;
        case (br)
            3'b001:  sel = 2'b01;
            3'b010:  sel = 2'b11;
            3'b100:  sel = z ? 2'b01 : 2'b00;
            3'b101:  sel = z ? 2'b00 : 2'b01;
            3'b110:  sel = l ? 2'b01 : 2'b00;
            3'b111:  sel = l ? 2'b00 : 2'b01;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        fault_nxt  = fault_q;
        retire     = 1'b0;
        imem_req_r = 1'b0;
        ir_we_r    = 1'b0;
        dmem_req_r = 1'b0;
        dmem_we_r  = 1'b0;
        reg_we_r   = 1'b0;
        pc_we_r    = 1'b0;
        pc_sel_r   = 2'b00;
        halted_r   = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req_r = 1'b1;
                if (imem_ready) begin
                    ir_we_r   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tcnt == T_LAST) begin
                    state_nxt = S_TRAP;
                    fault_nxt = FAULT_IMEM;
                end
            end

            S_DECODE: begin
                if (op_class == OP_ILLEGAL || branch == BR_ILLEGAL) begin
                    state_nxt = S_TRAP;
                    fault_nxt = FAULT_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_BRANCH, OP_JAL, OP_JALR: begin
                        pc_we_r   = 1'b1;
                        pc_sel_r  = branch_sel(br_q, zero, less);
                        reg_we_r  = (op_q != OP_BRANCH);
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_nxt = S_MEM;
                    default:           state_nxt = S_WB;
                endcase
            end

            S_MEM: begin
                dmem_req_r = 1'b1;
                dmem_we_r  = (op_q == OP_STORE);
                if (dmem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_we_r   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (tcnt == T_LAST) begin
                    state_nxt = S_TRAP;
                    fault_nxt = FAULT_DMEM;
                end
            end

            S_WB: begin
                reg_we_r  = 1'b1;
                pc_we_r   = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_TRAP:  halted_r  = 1'b1;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Counts consecutive request cycles without ready; anything else clears it, so entry to FETCH/MEM starts at zero.
    assign req_stall = (state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            op_q      <= OP_ALU;
            br_q      <= 3'b000;
            tcnt      <= '0;
            instret_q <= '0;
            fault_q   <= FAULT_NONE;
        end else begin
            state   <= state_nxt;
            fault_q <= fault_nxt;
            tcnt    <= req_stall ? tcnt + TW'(1) : '0;
            if (state == S_DECODE) begin
                op_q <= op_class;
                br_q <= branch;
            end
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Everything is forced low while reset is held, including the registered counters.
    assign imem_req   = imem_req_r & ~reset;
    assign ir_we      = ir_we_r    & ~reset;
    assign dmem_req   = dmem_req_r & ~reset;
    assign dmem_we    = dmem_we_r  & ~reset;
    assign reg_we     = reg_we_r   & ~reset;
    assign pc_we      = pc_we_r    & ~reset;
    assign PCBsrc     = pc_sel_r[1] & ~reset;
    assign PCAsrc     = pc_sel_r[0] & ~reset;
    assign halted     = halted_r   & ~reset;
    assign instret    = reset ? '0 : instret_q;
    assign fault_code = reset ? FAULT_NONE : fault_q;

endmodule
